// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a common-cathode seven-segment display with
// anti-ghost blanking and PWM brightness. Optional crossfade: SEG7_CROSSFADE_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2:0]            wr_digit,
    input  logic [3:0]            wr_bcd,
    input  logic                  wr_dp,
    input  logic [3:0]            brightness,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_tick
);

    localparam int CW = ($clog2(SCAN_DIV) > 8) ? $clog2(SCAN_DIV) : 8;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [3:0]    NUM_D4    = 4'(NUM_DIGITS);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [3:0]      digits [NUM_DIGITS];
    logic            dps    [NUM_DIGITS];
    logic            wrap, frame_end, accept, in_range, active;
    logic [3:0]      show_bcd;
    logic            show_dp;
    logic [7:0]            seg_d;
    logic [NUM_DIGITS-1:0] dig_d;

    function automatic logic [7:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 8'b11111100;
            4'd1:    decode = 8'b01100000;
            4'd2:    decode = 8'b11011010;
            4'd3:    decode = 8'b11110010;
            4'd4:    decode = 8'b01100110;
            4'd5:    decode = 8'b10110110;
            4'd6:    decode = 8'b10111110;
            4'd7:    decode = 8'b11100000;
            4'd8:    decode = 8'b11111110;
            4'd9:    decode = 8'b11110110;
            default: decode = 8'b00000000;
        endcase
    endfunction

    assign wrap      = (cnt == SLOT_LAST);
    assign frame_end = wrap && (idx == IDX_LAST);
    assign accept    = wr_valid && wr_ready;
    assign in_range  = ({1'b0, wr_digit} < NUM_D4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            state      <= (BLANK_CYCLES == 0) ? DRIVE : BLANK;
            seg        <= '0;
            dig_en     <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + CW'(1);
            state      <= state_next;
            seg        <= seg_d;
            dig_en     <= dig_d;
            frame_tick <= frame_end;
            if (wrap)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= 4'hF;
                dps[i]    <= 1'b0;
            end
        end else if (accept && in_range) begin
            digits[wr_digit[IW-1:0]] <= wr_bcd;
            dps[wr_digit[IW-1:0]]    <= wr_dp;
        end
    end

`ifdef SEG7_CROSSFADE_EN
    logic          fade_active;
    logic [IW-1:0] fade_pos;
    logic [3:0]    fade_bcd;
    logic          fade_dp;
    logic [3:0]    fade_step;

    // Fade ends on the frame_tick that takes the step from 14 to 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fade_active <= 1'b0;
            fade_pos    <= '0;
            fade_bcd    <= 4'hF;
            fade_dp     <= 1'b0;
            fade_step   <= '0;
        end else if (accept && in_range) begin
            fade_active <= 1'b1;
            fade_pos    <= wr_digit[IW-1:0];
            fade_bcd    <= digits[wr_digit[IW-1:0]];
            fade_dp     <= dps[wr_digit[IW-1:0]];
            fade_step   <= '0;
        end else if (fade_active && frame_end) begin
            fade_step <= fade_step + 4'd1;
            if (fade_step == 4'd14)
                fade_active <= 1'b0;
        end
    end

    assign wr_ready = !fade_active;

    always_comb begin
        show_bcd = digits[idx];
        show_dp  = dps[idx];
        if (fade_active && (fade_pos == idx) && !(cnt[7:4] < fade_step)) begin
            show_bcd = fade_bcd;
            show_dp  = fade_dp;
        end
    end
`else
    assign wr_ready = 1'b1;

    always_comb begin
        show_bcd = digits[idx];
        show_dp  = dps[idx];
    end
`endif

    always_comb begin
        state_next = state;
        seg_d      = '0;
        dig_d      = '0;
        active     = (brightness == 4'hF) || (cnt[3:0] < brightness);
        if (wrap)
            state_next = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        else if (cnt + CW'(1) == BLANK_END)
            state_next = DRIVE;
        if (state == DRIVE && active) begin
            seg_d = decode(show_bcd) | {7'b0, show_dp};
            dig_d = NUM_DIGITS'(1) << idx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=32, BLANK_CYCLES=4).
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_digit = '0;
    logic [3:0] wr_bcd = '0;
    logic       wr_dp = 1'b0;
    logic [3:0] brightness = 4'hF;
    logic [7:0] seg;
    logic [3:0] dig_en;
    logic       frame_tick;

    int passed = 0;
    int total  = 0;

    int         act [4];
    logic [7:0] sg  [4];
    int         bad;
    int         ticks;
    int         ticks_bad;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(32), .BLANK_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_digit(wr_digit), .wr_bcd(wr_bcd), .wr_dp(wr_dp), .brightness(brightness),
        .seg(seg), .dig_en(dig_en), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_write(input logic [2:0] d, input logic [3:0] b, input logic p);
        @(negedge clk);
        wr_valid = 1'b1; wr_digit = d; wr_bcd = b; wr_dp = p;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Waits for a frame_tick sample; the following 128 samples cover slots 0..3 in order.
    task automatic sync_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("frame_sync", {31'b0, frame_tick}, 32'd1);
    endtask

    task automatic scan_frame();
        int c, d;
        logic [3:0] onehot;
        sync_frame();
        bad = 0; ticks = 0; ticks_bad = 0;
        for (int k = 0; k < 4; k++) begin act[k] = 0; sg[k] = 'x; end
        for (int j = 0; j < 128; j++) begin
            @(negedge clk);
            c = j % 32; d = j / 32;
            onehot = 4'b0001 << d;
            if (frame_tick === 1'b1) ticks++;
            if ((frame_tick === 1'b1) != (j == 127)) ticks_bad++;
            if (dig_en === 4'b0000) begin
                if (seg !== 8'h00) bad++;
            end else if (dig_en === onehot && c >= 4) begin
                if (act[d] > 0 && seg !== sg[d]) bad++;
                sg[d] = seg;
                act[d]++;
            end else begin
                bad++;
            end
        end
    endtask

    initial begin
        #12;
        check("rst_seg", {24'b0, seg}, 32'h0);
        check("rst_dig_en", {28'b0, dig_en}, 32'h0);
        check("rst_frame_tick", {31'b0, frame_tick}, 32'h0);
        check("rst_wr_ready", {31'b0, wr_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Blank digits at full brightness: 28 enabled cycles per slot, seg stays 0
        scan_frame();
        check("blank_bad", bad, 0);
        check("blank_ticks", ticks, 1);
        check("blank_tick_pos", ticks_bad, 0);
        for (int k = 0; k < 4; k++) check("blank_act", act[k], 28);
        check("blank_seg", {24'b0, sg[0]}, 32'h0);

        do_write(3'd0, 4'd1, 1'b0);
        do_write(3'd1, 4'd2, 1'b0);
        do_write(3'd2, 4'd3, 1'b1);
        do_write(3'd3, 4'd4, 1'b0);
        check("wr_ready_idle", {31'b0, wr_ready}, 32'h1);
        scan_frame();
        check("digits_bad", bad, 0);
        check("seg_pos0", {24'b0, sg[0]}, 32'b01100000);
        check("seg_pos1", {24'b0, sg[1]}, 32'b11011010);
        check("seg_pos2", {24'b0, sg[2]}, 32'b11110011);
        check("seg_pos3", {24'b0, sg[3]}, 32'b01100110);
        check("act_pos2", act[2], 28);

        brightness = 4'd4;
        scan_frame();
        check("br4_bad", bad, 0);
        for (int k = 0; k < 4; k++) check("br4_act", act[k], 4);
        check("br4_seg_pos3", {24'b0, sg[3]}, 32'b01100110);

        brightness = 4'd0;
        scan_frame();
        check("br0_bad", bad, 0);
        for (int k = 0; k < 4; k++) check("br0_act", act[k], 0);

        brightness = 4'hF;
        do_write(3'd1, 4'd12, 1'b0);
        do_write(3'd5, 4'd7, 1'b1);
        check("wr_ready_oob", {31'b0, wr_ready}, 32'h1);
        scan_frame();
        check("bcd12_bad", bad, 0);
        check("bcd12_seg_pos1", {24'b0, sg[1]}, 32'h00);
        check("bcd12_act_pos1", act[1], 28);
        check("oob_seg_pos0", {24'b0, sg[0]}, 32'b01100000);
        check("oob_seg_pos2", {24'b0, sg[2]}, 32'b11110011);
        check("oob_seg_pos3", {24'b0, sg[3]}, 32'b01100110);

        // Reset in the middle of position 0's drive period
        sync_frame();
        repeat (10) @(negedge clk);
        check("pre_rst_dig_en", {28'b0, dig_en}, 32'b0001);
        check("pre_rst_seg", {24'b0, seg}, 32'b01100000);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg", {24'b0, seg}, 32'h0);
        check("async_rst_dig_en", {28'b0, dig_en}, 32'h0);
        check("async_rst_wr_ready", {31'b0, wr_ready}, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        scan_frame();
        check("post_rst_bad", bad, 0);
        for (int k = 0; k < 4; k++) begin
            check("post_rst_seg", {24'b0, sg[k]}, 32'h0);
            check("post_rst_act", act[k], 28);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule
